// File: rtl/tile_render_pipe_if.sv
// Tile-map and texture memory read ports of the tile renderer.
// The pipeline is the master: it issues addresses and consumes the returned data.
interface tile_render_pipe_if;
   logic        tile_ren;
   logic [11:0] tile_raddr;
   logic [5:0]  tile_rdata;
   logic        tex_ren;
   logic [11:0] tex_raddr;
   logic [2:0]  tex_rdata;

   modport master (
      output tile_ren, tile_raddr, tex_ren, tex_raddr,
      input  tile_rdata, tex_rdata
   );

   modport slave (
      input  tile_ren, tile_raddr, tex_ren, tex_raddr,
      output tile_rdata, tex_rdata
   );
endinterface

// File: rtl/tile_render_pipe.sv
// Three-stage scrolled tile renderer: map lookup, texel lookup, blanked RGB out.
// Advances only on px_en; scroll offsets latch once per frame at vsync pulse start.
module tile_render_pipe #(
   parameter logic SYNC_IDLE = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      px_en,
   input  logic [9:0]                x_px,
   input  logic [9:0]                y_px,
   input  logic                      active_in,
   input  logic                      hsync_in,
   input  logic                      vsync_in,
   input  logic [8:0]                scroll_x,
   input  logic [8:0]                scroll_y,
   tile_render_pipe_if.master        mem,
   output logic                      vga_r,
   output logic                      vga_g,
   output logic                      vga_b,
   output logic                      vga_hsync,
   output logic                      vga_vsync
);

   logic [8:0] sx, sy;
   logic [8:0] wx, wy;
   logic       vs_prev;
   logic [2:0] wx_s1, wy_s1;
   logic       act_s1, hs_s1, vs_s1;
   logic       act_s2, hs_s2, vs_s2;
   logic       scroll_load;
   logic       unused_msb;

   // Bit 9 of the pixel coordinates cannot affect a mod-512 sum.
   assign unused_msb = ^{x_px[9], y_px[9]};

   assign wx = x_px[8:0] + sx;
   assign wy = y_px[8:0] + sy;
   assign scroll_load = (vsync_in != SYNC_IDLE) && (vs_prev == SYNC_IDLE);

   always_comb begin
      mem.tile_ren   = px_en & ~reset;
      mem.tile_raddr = {wy[8:3], wx[8:3]};
      mem.tex_ren    = px_en & ~reset;
      mem.tex_raddr  = {mem.tile_rdata, wy_s1, wx_s1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sx        <= '0;
         sy        <= '0;
         vs_prev   <= SYNC_IDLE;
         wx_s1     <= '0;
         wy_s1     <= '0;
         act_s1    <= 1'b0;
         hs_s1     <= SYNC_IDLE;
         vs_s1     <= SYNC_IDLE;
         act_s2    <= 1'b0;
         hs_s2     <= SYNC_IDLE;
         vs_s2     <= SYNC_IDLE;
         vga_r     <= 1'b0;
         vga_g     <= 1'b0;
         vga_b     <= 1'b0;
         vga_hsync <= SYNC_IDLE;
         vga_vsync <= SYNC_IDLE;
      end else if (px_en) begin
         // The loading tick itself still renders with the previous frame's offsets.
         if (scroll_load) begin
            sx <= scroll_x;
            sy <= scroll_y;
         end
         vs_prev   <= vsync_in;
         wx_s1     <= wx[2:0];
         wy_s1     <= wy[2:0];
         act_s1    <= active_in;
         hs_s1     <= hsync_in;
         vs_s1     <= vsync_in;
         act_s2    <= act_s1;
         hs_s2     <= hs_s1;
         vs_s2     <= vs_s1;
         vga_r     <= act_s2 & mem.tex_rdata[2];
         vga_g     <= act_s2 & mem.tex_rdata[1];
         vga_b     <= act_s2 & mem.tex_rdata[0];
         vga_hsync <= hs_s2;
         vga_vsync <= vs_s2;
      end
   end

endmodule

// File: tb/tb_tile_render_pipe.sv
// Bench for tile_render_pipe: directed scroll/wrap/reset steps, then randomized pixels
// with random tick gaps, checked against a per-pixel history model.
module tb_tile_render_pipe;
   localparam bit IDLE = 1'b1;

   logic       clk;
   logic       reset;
   logic       px_en;
   logic [9:0] x_px, y_px;
   logic       active_in, hsync_in, vsync_in;
   logic [8:0] scroll_x, scroll_y;
   logic       vga_r, vga_g, vga_b, vga_hsync, vga_vsync;

   tile_render_pipe_if bus ();

   tile_render_pipe #(.SYNC_IDLE(IDLE)) dut (
      .clk       (clk),
      .reset     (reset),
      .px_en     (px_en),
      .x_px      (x_px),
      .y_px      (y_px),
      .active_in (active_in),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .scroll_x  (scroll_x),
      .scroll_y  (scroll_y),
      .mem       (bus),
      .vga_r     (vga_r),
      .vga_g     (vga_g),
      .vga_b     (vga_b),
      .vga_hsync (vga_hsync),
      .vga_vsync (vga_vsync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int wx;
      int wy;
      bit act;
      bit hs;
      bit vs;
   } pix_t;

   pix_t hist[$];
   int   msx, msy;
   bit   mvs_prev;
   int   exp_rgb;
   bit   exp_hs, exp_vs;
   int   checks = 0;
   int   errors = 0;
   logic [11:0] obs_tile, obs_tex;

   task automatic chk(input string tag, input logic [11:0] obs, input int expv);
      checks++;
      assert (obs === 12'(expv))
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, 12'(expv));
      end
   endtask

   task automatic check_out();
      chk("rgb", {9'd0, vga_r, vga_g, vga_b}, exp_rgb);
      chk("hsync", {11'd0, vga_hsync}, int'(exp_hs));
      chk("vsync", {11'd0, vga_vsync}, int'(exp_vs));
   endtask

   // Pipeline restarts empty: two bubble pixels precede the first real one.
   task automatic model_reset();
      msx = 0; msy = 0; mvs_prev = IDLE;
      hist.delete();
      repeat (2) hist.push_back('{0, 0, 1'b0, IDLE, IDLE});
      exp_rgb = 0; exp_hs = IDLE; exp_vs = IDLE;
   endtask

   task automatic junk_inputs();
      x_px = 10'($urandom); y_px = 10'($urandom);
      active_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      scroll_x = 9'($urandom); scroll_y = 9'($urandom);
      bus.tile_rdata = 6'($urandom); bus.tex_rdata = 3'($urandom);
   endtask

   task automatic reset_cycle();
      reset = 1'b1; px_en = 1'($urandom); junk_inputs();
      #1;
      chk("rst_tile_ren", {11'd0, bus.tile_ren}, 0);
      chk("rst_tex_ren", {11'd0, bus.tex_ren}, 0);
      @(posedge clk); #1;
      model_reset();
      check_out();
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      reset = 1'b0; px_en = 1'b0; junk_inputs();
      #1;
      chk("idle_tile_ren", {11'd0, bus.tile_ren}, 0);
      chk("idle_tex_ren", {11'd0, bus.tex_ren}, 0);
      @(posedge clk); #1;
      check_out();
      @(negedge clk);
   endtask

   task automatic tick(input int gap, input int x, input int y, input bit act, input bit hs,
                       input bit vs, input int td, input int xd, input int sxv, input int syv);
      pix_t prev, older;
      int ewx, ewy;
      repeat (gap) idle_cycle();
      reset = 1'b0; px_en = 1'b1;
      x_px = 10'(x); y_px = 10'(y); active_in = act; hsync_in = hs; vsync_in = vs;
      scroll_x = 9'(sxv); scroll_y = 9'(syv);
      bus.tile_rdata = 6'(td); bus.tex_rdata = 3'(xd);
      #1;
      ewx = (x + msx) % 512;
      ewy = (y + msy) % 512;
      prev = hist[hist.size() - 1];
      older = hist[hist.size() - 2];
      obs_tile = bus.tile_raddr;
      obs_tex = bus.tex_raddr;
      chk("tile_ren", {11'd0, bus.tile_ren}, 1);
      chk("tex_ren", {11'd0, bus.tex_ren}, 1);
      chk("tile_raddr", obs_tile, (ewy / 8) * 64 + ewx / 8);
      chk("tex_raddr", obs_tex, td * 64 + (prev.wy % 8) * 8 + prev.wx % 8);
      exp_rgb = older.act ? xd : 0;
      exp_hs = older.hs;
      exp_vs = older.vs;
      hist.push_back('{ewx, ewy, act, hs, vs});
      if (hist.size() > 3) void'(hist.pop_front());
      if (vs != IDLE && mvs_prev == IDLE) begin
         msx = sxv; msy = syv;
      end
      mvs_prev = vs;
      @(posedge clk); #1;
      check_out();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; px_en = 1'b0;
      junk_inputs();
      reset_cycle();
      reset_cycle();

      // Basic lookup with zero scroll, then its texel and colour two ticks later.
      tick(0, 17, 9, 1, 1, 1, 6'h3f, 0, 0, 0);
      chk("basic_tile_addr", obs_tile, 12'h042);
      tick(0, 0, 0, 1, 1, 1, 6'h05, 0, 0, 0);
      chk("basic_tex_addr", obs_tex, 12'h149);
      tick(0, 0, 0, 1, 1, 1, 0, 3'b101, 0, 0);
      chk("basic_rgb", {9'd0, vga_r, vga_g, vga_b}, 3'b101);

      // Scroll load with wrap in both axes.
      tick(0, 0, 0, 1, 1, 0, 0, 0, 500, 510);
      tick(0, 20, 5, 1, 1, 1, 0, 0, 0, 0);
      chk("wrap_tile_addr", obs_tile, 12'h001);

      // Mid-frame scroll change must wait for the next vsync pulse start.
      tick(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 1, 1, 0, 0, 40, 0);
      chk("scroll_held", obs_tile, 0);
      tick(2, 0, 0, 1, 1, 0, 0, 0, 40, 0);
      chk("scroll_load_tick", obs_tile, 0);
      tick(0, 0, 0, 1, 1, 1, 0, 0, 7, 7);
      chk("scroll_applied", obs_tile, 5);

      // Blanking with sync pass-through, ticks every 3rd clock.
      tick(2, 3, 3, 0, 0, 0, 1, 7, 0, 0);
      tick(2, 4, 3, 0, 1, 1, 2, 7, 0, 0);
      tick(2, 5, 3, 0, 1, 1, 3, 7, 0, 0);
      chk("blank_rgb", {9'd0, vga_r, vga_g, vga_b}, 0);
      chk("blank_hsync", {11'd0, vga_hsync}, 0);

      // Reset with a pixel in flight: nothing stale may emerge.
      tick(0, 9, 9, 1, 1, 1, 7, 7, 0, 0);
      tick(0, 9, 9, 1, 1, 1, 7, 7, 0, 0);
      reset_cycle();
      tick(0, 1, 1, 1, 1, 1, 7, 7, 0, 0);
      tick(0, 1, 1, 1, 1, 1, 7, 7, 0, 0);
      chk("post_reset_rgb", {9'd0, vga_r, vga_g, vga_b}, 0);

      for (int i = 0; i < 400; i++) begin
         int gap;
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         if (i == 200) reset_cycle();
         tick(gap, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1,
              int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
